// File: rtl/reservation_station.sv
// reservation_station: N-entry ALU reservation station with CDB wake-up and locked issue.
// Define RS_WAKEUP_BYPASS_EN to let a CDB wake-up issue in the same cycle.
module reservation_station #(
    parameter int NRENTRY  = 4,
    parameter int BITWIDTH = 32,
    parameter int TAGWIDTH = 5,
    parameter int NRALUOP  = 8,
    localparam int OPW = $clog2(NRALUOP),
    localparam int CW  = $clog2(NRENTRY + 1),
    localparam int IW  = NRENTRY > 1 ? $clog2(NRENTRY) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OPW-1:0]             disp_op,
    input  logic [TAGWIDTH+BITWIDTH:0] disp_src1,
    input  logic [TAGWIDTH+BITWIDTH:0] disp_src2,
    input  logic [TAGWIDTH-1:0]        disp_tag,
    input  logic                       cdb_valid,
    input  logic [TAGWIDTH-1:0]        cdb_tag,
    input  logic [BITWIDTH-1:0]        cdb_value,
    input  logic                       flush,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OPW-1:0]             iss_op,
    output logic [BITWIDTH-1:0]        iss_a,
    output logic [BITWIDTH-1:0]        iss_b,
    output logic [TAGWIDTH-1:0]        iss_tag,
    output logic [CW-1:0]              occupancy
);
    typedef struct packed {
        logic                valid;
        logic [TAGWIDTH-1:0] tag;
        logic [BITWIDTH-1:0] value;
    } rat_t;

    rat_t                s1 [NRENTRY];
    rat_t                s2 [NRENTRY];
    logic [OPW-1:0]      op_q [NRENTRY];
    logic [TAGWIDTH-1:0] tag_q [NRENTRY];
    logic [NRENTRY-1:0]  busy, w1, w2, rdy;
    logic                locked, any_rdy, has_free, disp_fire, iss_fire;
    logic [IW-1:0]       lock_idx, rdy_idx, free_idx, sel;
    logic [CW-1:0]       occ;
    rat_t                d1, d2, in1, in2;
    logic [BITWIDTH-1:0] a_raw, b_raw;

    assign in1 = disp_src1;
    assign in2 = disp_src2;

    // Operands arriving on the CDB in the dispatch cycle are stored already resolved
    always_comb begin
        d1 = in1;
        d2 = in2;
        if (!in1.valid && cdb_valid && in1.tag == cdb_tag) d1 = '{valid: 1'b1, tag: in1.tag, value: cdb_value};
        if (!in2.valid && cdb_valid && in2.tag == cdb_tag) d2 = '{valid: 1'b1, tag: in2.tag, value: cdb_value};
    end

    always_comb begin
        w1 = '0;
        w2 = '0;
        rdy = '0;
        for (int i = 0; i < NRENTRY; i++) begin
            w1[i] = cdb_valid && !s1[i].valid && s1[i].tag == cdb_tag;
            w2[i] = cdb_valid && !s2[i].valid && s2[i].tag == cdb_tag;
`ifdef RS_WAKEUP_BYPASS_EN
            rdy[i] = busy[i] && (s1[i].valid || w1[i]) && (s2[i].valid || w2[i]);
`else
            rdy[i] = busy[i] && s1[i].valid && s2[i].valid;
`endif
        end
    end

    // Descending scan leaves the lowest matching index in place
    always_comb begin
        free_idx = '0;
        has_free = 1'b0;
        rdy_idx  = '0;
        any_rdy  = 1'b0;
        for (int i = NRENTRY - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IW'(i);
                has_free = 1'b1;
            end
            if (rdy[i]) begin
                rdy_idx = IW'(i);
                any_rdy = 1'b1;
            end
        end
    end

    assign sel        = locked ? lock_idx : rdy_idx;
    assign iss_valid  = locked || any_rdy;
    assign iss_fire   = iss_valid && iss_ready;
    assign disp_ready = occ < CW'(NRENTRY) && !flush;
    assign disp_fire  = disp_valid && disp_ready && has_free;
    assign occupancy  = occ;

`ifdef RS_WAKEUP_BYPASS_EN
    assign a_raw = w1[sel] ? cdb_value : s1[sel].value;
    assign b_raw = w2[sel] ? cdb_value : s2[sel].value;
`else
    assign a_raw = s1[sel].value;
    assign b_raw = s2[sel].value;
`endif

    assign iss_op  = iss_valid ? op_q[sel] : '0;
    assign iss_a   = iss_valid ? a_raw : '0;
    assign iss_b   = iss_valid ? b_raw : '0;
    assign iss_tag = iss_valid ? tag_q[sel] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
            occ      <= '0;
            for (int i = 0; i < NRENTRY; i++) begin
                s1[i]    <= '0;
                s2[i]    <= '0;
                op_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            busy   <= '0;
            locked <= 1'b0;
            occ    <= '0;
        end else begin
            for (int i = 0; i < NRENTRY; i++) begin
                if (busy[i] && w1[i]) s1[i] <= '{valid: 1'b1, tag: s1[i].tag, value: cdb_value};
                if (busy[i] && w2[i]) s2[i] <= '{valid: 1'b1, tag: s2[i].tag, value: cdb_value};
            end
            if (iss_fire) busy[sel] <= 1'b0;
            if (disp_fire) begin
                busy[free_idx]  <= 1'b1;
                s1[free_idx]    <= d1;
                s2[free_idx]    <= d2;
                op_q[free_idx]  <= disp_op;
                tag_q[free_idx] <= disp_tag;
            end
            locked   <= iss_valid && !iss_ready;
            lock_idx <= sel;
            occ      <= occ + CW'(disp_fire) - CW'(iss_fire);
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed steps with an issue scoreboard for reservation_station.
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_valid = 1'b0, disp_ready;
    logic [2:0]  disp_op = '0;
    logic [37:0] disp_src1 = '0, disp_src2 = '0;
    logic [4:0]  disp_tag = '0;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic        flush = 1'b0;
    logic        iss_valid, iss_ready = 1'b0;
    logic [2:0]  iss_op;
    logic [31:0] iss_a, iss_b;
    logic [4:0]  iss_tag;
    logic [2:0]  occupancy;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    reservation_station dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] src(input logic v, input logic [4:0] t, input logic [31:0] val);
        return {v, t, val};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Issue handshakes are scored mid-cycle; inputs default back to idle after each edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst && !flush && iss_valid && iss_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_issue", {27'd0, iss_op, iss_tag, iss_a[28:0]}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("issue", {iss_op, iss_a, iss_b, iss_tag}, e);
            end
        end
        @(posedge clk);
        #1;
        disp_valid = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic disp(input logic [2:0] op, input logic [37:0] a, input logic [37:0] b, input logic [4:0] t);
        disp_valid = 1'b1;
        disp_op = op;
        disp_src1 = a;
        disp_src2 = b;
        disp_tag = t;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag = t;
        cdb_value = v;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b1;
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_iss_op", iss_op, 0);
        chk("rst_iss_a", iss_a, 0);
        chk("rst_iss_b", iss_b, 0);
        chk("rst_iss_tag", iss_tag, 0);

        // Basic dispatch of two ready operands
        disp(3, src(1, 0, 5), src(1, 0, 7), 9);
        q.push_back('{3'd3, 32'd5, 32'd7, 5'd9});
        tick();
        chk("t1_valid", iss_valid, 1);
        chk("t1_a", iss_a, 5);
        chk("t1_b", iss_b, 7);
        chk("t1_tag", iss_tag, 9);
        chk("t1_occ", occupancy, 1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("t1_occ_after", occupancy, 0);
        chk("t1_valid_after", iss_valid, 0);

        // Wake-up from the CDB after dispatch
        disp(1, src(0, 4, 0), src(1, 0, 2), 2);
        q.push_back('{3'd1, 32'hAB, 32'd2, 5'd2});
        tick();
        chk("t2_wait", iss_valid, 0);
        cdb(4, 32'hAB);
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        chk("t2_bypass_valid", iss_valid, 1);
        chk("t2_bypass_a", iss_a, 32'hAB);
`else
        chk("t2_nobypass_valid", iss_valid, 0);
`endif
        tick();
        chk("t2_valid", iss_valid, 1);
        chk("t2_a", iss_a, 32'hAB);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;

        // CDB match in the dispatch cycle itself
        disp(2, src(1, 0, 3), src(0, 6, 0), 7);
        cdb(6, 32'h11);
        q.push_back('{3'd2, 32'd3, 32'h11, 5'd7});
        tick();
        chk("t3_valid", iss_valid, 1);
        chk("t3_b", iss_b, 32'h11);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("t3_occ", occupancy, 0);

        // Fill, overflow attempt, locked issue while entry 1 wakes
        disp(4, src(1, 0, 10), src(1, 0, 20), 10);
        q.push_back('{3'd4, 32'd10, 32'd20, 5'd10});
        tick();
        disp(5, src(0, 20, 0), src(1, 0, 1), 11);
        q.push_back('{3'd5, 32'h55, 32'd1, 5'd11});
        tick();
        disp(6, src(0, 21, 0), src(1, 0, 2), 12);
        q.push_back('{3'd6, 32'h77, 32'd2, 5'd12});
        tick();
        disp(7, src(1, 0, 3), src(0, 21, 0), 13);
        q.push_back('{3'd7, 32'd3, 32'h77, 5'd13});
        tick();
        chk("t4_full_ready", disp_ready, 0);
        chk("t4_full_occ", occupancy, 4);
        disp(1, src(1, 0, 99), src(1, 0, 98), 15);
        tick();
        chk("t4_ignored_occ", occupancy, 4);
        chk("t4_lock_tag", iss_tag, 10);
        cdb(20, 32'h55);
        tick();
        chk("t4_lock_tag2", iss_tag, 10);
        chk("t4_lock_a", iss_a, 10);
        iss_ready = 1'b1;
        tick();
        chk("t4_occ_3", occupancy, 3);
        chk("t4_next_tag", iss_tag, 11);
        chk("t4_next_a", iss_a, 32'h55);
        cdb(21, 32'h77);
        tick();
        tick();
        tick();
        chk("t4_drained", occupancy, 0);
        iss_ready = 1'b0;

        // Flush with a coincident dispatch
        disp(1, src(0, 30, 0), src(1, 0, 1), 20);
        tick();
        disp(1, src(0, 30, 0), src(1, 0, 1), 21);
        tick();
        disp(1, src(0, 30, 0), src(1, 0, 1), 22);
        tick();
        chk("t5_occ3", occupancy, 3);
        disp(2, src(1, 0, 1), src(1, 0, 1), 31);
        flush = 1'b1;
        tick();
        chk("t5_occ", occupancy, 0);
        chk("t5_valid", iss_valid, 0);
        iss_ready = 1'b1;
        cdb(30, 32'h1);
        tick();
        tick();
        chk("t5_still_idle", iss_valid, 0);
        iss_ready = 1'b0;

        // Reset mid-stream while an issue is offered
        disp(3, src(1, 0, 4), src(1, 0, 5), 3);
        tick();
        chk("t6_pre_valid", iss_valid, 1);
        iss_ready = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_valid", iss_valid, 0);
        chk("t6_occ", occupancy, 0);
        chk("t6_disp_ready", disp_ready, 1);
        chk("t6_op", iss_op, 0);
        chk("t6_a", iss_a, 0);
        chk("t6_b", iss_b, 0);
        chk("t6_tag", iss_tag, 0);
        tick();
        iss_ready = 1'b0;
        chk("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The block SHALL have parameter NRENTRY, default 4: number of station entries.
REQ-002 The block SHALL have parameter BITWIDTH, default 32: operand and data width.
REQ-003 The block SHALL have parameter TAGWIDTH, default 5: producer-tag width, matching RAT_t.Tag.
REQ-004 The block SHALL have parameter NRALUOP, default 8: number of ALU opcodes; OPW = $clog2(NRALUOP).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port disp_valid, input, 1 bit: dispatch request.
REQ-008 The block SHALL have port disp_ready, output, 1 bit: station can accept a dispatch.
REQ-009 The block SHALL have port disp_op, input, OPW bits: ALU opcode.
REQ-010 The block SHALL have ports disp_src1 and disp_src2, input, RAT_t each: operands as read from the RAT; Valid=1 means Value is usable, Valid=0 means wait on Tag.
REQ-011 The block SHALL have port disp_tag, input, TAGWIDTH bits: destination tag of the dispatched instruction.
REQ-012 The block SHALL have ports cdb_valid (1 bit), cdb_tag (TAGWIDTH bits) and cdb_value (BITWIDTH bits), all inputs: common data bus broadcast.
REQ-013 The block SHALL have port flush, input, 1 bit: discard all entries.
REQ-014 The block SHALL have ports iss_valid (output, 1 bit) and iss_ready (input, 1 bit): issue handshake to the ALU.
REQ-015 The block SHALL have ports iss_op (OPW bits), iss_a and iss_b (BITWIDTH bits each), and iss_tag (TAGWIDTH bits), all outputs: the issued instruction.
REQ-016 The block SHALL have port occupancy, output, $clog2(NRENTRY+1) bits: count of busy entries.

Function
REQ-017 disp_ready SHALL equal 1 when occupancy < NRENTRY and flush is 0; an entry freed by issue this cycle SHALL NOT be reusable until the next cycle.
REQ-018 A dispatch SHALL occur when disp_valid and disp_ready are both 1; it allocates the lowest-index free entry and stores op, tag, and both operands.
REQ-019 A dispatch operand with Valid=0 whose Tag equals cdb_tag while cdb_valid=1 in the same cycle SHALL be stored as Valid=1 with Value=cdb_value.
REQ-020 Each busy entry operand with Valid=0 and Tag==cdb_tag SHALL capture cdb_value and set Valid=1 when cdb_valid=1; all matching entries capture in the same cycle.
REQ-021 An entry SHALL be ready when it is busy and both operand Valid bits are 1.
REQ-022 Selection SHALL pick the lowest-index ready entry; iss_valid SHALL be 1 when a ready entry exists or an entry is locked.
REQ-023 When iss_valid=1 and iss_ready=0, the selected entry SHALL be locked, and iss_op, iss_a, iss_b and iss_tag SHALL stay stable until acceptance, even if a lower-index entry becomes ready.
REQ-024 When iss_valid and iss_ready are both 1, the selected entry SHALL be freed at the clock edge and the lock cleared.
REQ-025 Simultaneous dispatch, issue and CDB capture SHALL all take effect in one cycle; occupancy SHALL update by +1, −1 or 0 accordingly.
REQ-026 When flush=1, all entries SHALL be freed and the lock cleared at the edge, a dispatch in the same cycle SHALL be dropped, and iss_valid SHALL be 0 in the following cycle.
REQ-027 With the station full, disp_valid=1 SHALL have no effect and no state SHALL change on the dispatch path.

Reset
REQ-028 When rst=0 at a rising clk edge, all entries SHALL become free with operand fields cleared to 0, and the lock SHALL be cleared.
REQ-029 After reset, iss_valid SHALL be 0, disp_ready SHALL be 1, occupancy SHALL be 0, and iss_op, iss_a, iss_b and iss_tag SHALL be 0.
REQ-030 Reset SHALL take priority over flush, dispatch, CDB capture and issue.

Configuration
REQ-031 With macro RS_WAKEUP_BYPASS_EN defined, an entry whose last missing operand matches the CDB in the current cycle SHALL be selectable in that same cycle, with that operand driven from cdb_value (wake-up to issue in 0 cycles).
REQ-032 With RS_WAKEUP_BYPASS_EN undefined, selection SHALL use registered operand Valid bits only, so that entry issues no earlier than the next cycle.

Verification
REQ-033 The bench SHALL cover: after reset, dispatch op=3 with src1 {1,0,5}, src2 {1,0,7} and tag 9 -> next cycle iss_valid=1, iss_a=5, iss_b=7, iss_tag=9, occupancy=1.
REQ-034 The bench SHALL cover: dispatch src1 {0,4,x} with tag 2, then CDB tag 4 value 0xAB -> iss_a=0xAB one cycle later without the macro and in the same cycle with it.
REQ-035 The bench SHALL cover: dispatch with src2 waiting on tag 6 while the CDB broadcasts tag 6 value 0x11 in the same cycle -> stored Valid, and issue next cycle with iss_b=0x11.
REQ-036 The bench SHALL cover: fill 4 entries with iss_ready=0 -> disp_ready=0, the 5th dispatch is ignored, entry 0 stays locked on iss outputs while entry 1 becomes ready, and on acceptance occupancy goes 4->3.
REQ-037 The bench SHALL cover: flush asserted together with disp_valid while 3 entries are busy -> occupancy=0 and iss_valid=0 next cycle, with the dropped dispatch never issued.
REQ-038 The bench SHALL cover: rst=0 mid-stream with iss_valid=1 -> all outputs at reset values after the edge, and no issue occurs.
